// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: samples the PC, runs a req/ack read against instruction memory,
// latches the word into the instruction register and pulses the PC increment once per fetch.
module fetch_unit #(
  parameter int unsigned IW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          RST,
  input  logic          fetch_en,
  input  logic          flush,
  input  logic [7:0]    pc_in,
  output logic [7:0]    mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir_out,
  output logic          ir_valid,
  output logic          pc_inc,
  output logic          busy,
  output logic          fetch_err
);

  // A zero-width counter is illegal, so TIMEOUT=0 still keeps one (unused) bit.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      ir_out    <= '0;
      ir_valid  <= 1'b0;
      pc_inc    <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      pc_inc   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fetch_en && !flush) begin
            mem_addr <= pc_in;
            cnt_q    <= '0;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StReq;
          end
        end
        StReq: begin
          // Flush wins over a same-cycle ack; the returned word is dropped.
          if (flush) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (mem_ack) begin
            ir_out   <= mem_rdata;
            ir_valid <= 1'b1;
            pc_inc   <= 1'b1;
            mem_req  <= 1'b0;
            state_q  <= StDone;
          end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state_q   <= StErr;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StErr: begin
          // Sticky until reset.
          state_q <= StErr;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a PC register model, a memory responder with
// configurable ack latency, and a monitor that checks each delivered instruction.
module tb_fetch_unit;

  localparam int unsigned IW = 16;
  localparam int unsigned TO = 15;

  logic          Clk = 1'b0;
  logic          RST;
  logic          fetch_en;
  logic          flush;
  logic [7:0]    pc_in;
  logic [7:0]    mem_addr;
  logic          mem_req;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] ir_out;
  logic          ir_valid;
  logic          pc_inc;
  logic          busy;
  logic          fetch_err;

  fetch_unit #(.IW(IW), .TIMEOUT(TO)) dut (
    .Clk      (Clk),
    .RST      (RST),
    .fetch_en (fetch_en),
    .flush    (flush),
    .pc_in    (pc_in),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir_out   (ir_out),
    .ir_valid (ir_valid),
    .pc_inc   (pc_inc),
    .busy     (busy),
    .fetch_err(fetch_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // PC register environment model
  logic [7:0] pc_q = 8'd0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_val = 8'd0;
  always @(posedge Clk) begin
    if (pc_load) pc_q <= pc_load_val;
    else if (pc_inc) pc_q <= pc_q + 8'd1;
  end
  assign pc_in = pc_q;

  // Instruction memory contents
  logic [IW-1:0] rom [256];

  // Reference model: fetch n reads address start+n and delivers rom[that address]
  typedef struct packed {
    logic [7:0]    addr;
    logic [IW-1:0] data;
  } exp_t;
  exp_t          exp_q[$];
  logic [7:0]    model_pc = 8'd0;
  logic [IW-1:0] last_ir  = '0;

  task automatic push_fetches(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: model_pc, data: rom[model_pc]});
      last_ir  = rom[model_pc];
      model_pc = model_pc + 8'd1;
    end
  endtask

  // Memory responder. Modes: 0 manual, 1 ack tied high, 2 fixed delay, 3 random delay.
  int ack_mode    = 0;
  int fixed_delay = 0;
  int cur_delay   = 0;
  int wcnt        = 0;
  bit in_req      = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (!mem_req) in_req = 0;
      case (ack_mode)
        1: begin
          mem_ack   = 1'b1;
          mem_rdata = rom[mem_addr];
          cur_delay = 0;
        end
        2, 3: begin
          if (mem_req) begin
            if (!in_req) begin
              in_req    = 1;
              wcnt      = 0;
              cur_delay = (ack_mode == 2) ? fixed_delay : int'($urandom_range(0, 5));
            end
            mem_ack   = (wcnt == cur_delay);
            mem_rdata = rom[mem_addr];
            wcnt++;
          end else begin
            mem_ack = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Monitor / scoreboard
  int         cyc = 0;
  int         last_v = -1;
  bit         spacing_on = 0;
  bit         prev_req = 0;
  int         req_len = 0;
  logic [7:0] req_addr = 8'd0;

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      cyc++;
      if (mem_req) begin
        if (!prev_req) begin
          req_len  = 1;
          req_addr = mem_addr;
        end else begin
          req_len++;
          check("addr_stable", mem_addr, req_addr);
        end
      end
      prev_req = mem_req;
      if (ir_valid || pc_inc) check("pc_inc_eq_ir_valid", pc_inc, ir_valid);
      if (ir_valid) begin
        check("ir_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ir_out", ir_out, e.data);
          check("fetch_addr", req_addr, e.addr);
          if (ack_mode != 0) check("req_len", req_len, cur_delay + 1);
        end
        if (spacing_on && last_v >= 0) check("fetch_spacing", cyc - last_v, 3);
        last_v = cyc;
      end
    end
  end

  task automatic load_pc(input logic [7:0] v);
    @(negedge Clk);
    pc_load = 1'b1;
    pc_load_val = v;
    @(negedge Clk);
    pc_load = 1'b0;
    model_pc = v;
  endtask

  // Waits for n ir_valid pulses; returns at the negedge of the last one.
  task automatic wait_fetches(input int n, input int bound);
    int cnt = 0;
    for (int i = 0; i < bound && cnt < n; i++) begin
      @(negedge Clk);
      if (ir_valid) cnt++;
    end
    check("fetches_done", cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqc;
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    rom[12] = 16'hA55A;

    // Reset held with fetch_en and ack high
    RST = 1'b1; fetch_en = 1'b1; flush = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    repeat (2) begin
      @(negedge Clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_busy", busy, 0);
      check("rst_outs", {mem_addr, ir_out, ir_valid, pc_inc, fetch_err}, 0);
    end
    RST = 1'b0; fetch_en = 1'b0; mem_ack = 1'b0;

    // Zero-wait single fetch
    ack_mode = 1;
    load_pc(8'd12);
    push_fetches(1);
    @(negedge Clk); fetch_en = 1'b1;
    @(negedge Clk); fetch_en = 1'b0;
    check("zw_mem_addr", mem_addr, 12);
    wait_fetches(1, 10);
    repeat (2) @(negedge Clk);
    check("zw_busy_after", busy, 0);
    check("zw_pc", pc_in, 13);

    // Back-to-back fetches
    load_pc(8'd34);
    push_fetches(3);
    last_v = -1; spacing_on = 1;
    @(negedge Clk); fetch_en = 1'b1;
    wait_fetches(3, 30);
    fetch_en = 1'b0;
    repeat (3) @(negedge Clk);
    spacing_on = 0;
    check("b2b_pc", pc_in, 37);
    check("b2b_busy", busy, 0);

    // Four wait states
    ack_mode = 2; fixed_delay = 4;
    load_pc(8'd90);
    push_fetches(1);
    @(negedge Clk); fetch_en = 1'b1;
    @(negedge Clk); fetch_en = 1'b0;
    wait_fetches(1, 20);
    repeat (2) @(negedge Clk);
    check("ws_pc", pc_in, 91);

    // Random latencies, PC wrapping past 255
    ack_mode = 3;
    load_pc(8'd245);
    push_fetches(20);
    @(negedge Clk); fetch_en = 1'b1;
    wait_fetches(20, 400);
    fetch_en = 1'b0;
    repeat (3) @(negedge Clk);
    check("rnd_pc", pc_in, 8'd9);
    check("rnd_busy", busy, 0);

    // Flush coincident with ack
    ack_mode = 0; mem_ack = 1'b0;
    load_pc(8'd50);
    @(negedge Clk); fetch_en = 1'b1;
    @(negedge Clk); fetch_en = 1'b0;
    check("fl_req", mem_req, 1);
    mem_ack = 1'b1; flush = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge Clk);
    check("fl_mem_req", mem_req, 0);
    check("fl_busy", busy, 0);
    check("fl_ir_out", ir_out, last_ir);
    check("fl_pulses", {ir_valid, pc_inc}, 0);
    flush = 1'b0;
    repeat (2) @(negedge Clk);
    check("fl_idle_ack_ignored", {busy, mem_req}, 0);
    check("fl_pc", pc_in, 50);
    mem_ack = 1'b0;

    // Reset mid-REQ
    @(negedge Clk); fetch_en = 1'b1;
    @(negedge Clk); fetch_en = 1'b0;
    @(negedge Clk); RST = 1'b1;
    @(negedge Clk); RST = 1'b0;
    last_ir = '0;
    check("mr_req_busy", {mem_req, busy}, 0);
    check("mr_ir_out", ir_out, 0);
    check("mr_pc", pc_in, 50);

    // Timeout with no ack
    reqc = 0;
    @(negedge Clk); fetch_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (i == 0) fetch_en = 1'b0;
      if (mem_req) reqc++;
      if (fetch_err) break;
    end
    check("to_req_cycles", reqc, TO);
    check("to_fetch_err", fetch_err, 1);
    check("to_mem_req", mem_req, 0);
    check("to_busy", busy, 1);
    fetch_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      flush = i[0];
      @(negedge Clk);
    end
    fetch_en = 1'b0; flush = 1'b0;
    check("to_sticky", {fetch_err, mem_req, busy}, 3'b101);
    RST = 1'b1;
    @(negedge Clk); RST = 1'b0;
    check("to_rst_clear", {fetch_err, busy, mem_req}, 0);

    @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
